// File: rtl/lock_pkg.sv
// Shared definitions for the lock code sequencer: FSM state encodings,
// a constant ceil-log2 helper and the digit width derivation.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED   = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_PROGRAM  = 3'd4,
    ST_ERROR    = 3'd5
  } lock_state_t;

  // Ceil(log2(value)); clog2(0) and clog2(1) both return 0.
  function automatic int clog2(input int unsigned value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Bits needed to hold a key index; at least one bit even for a single key.
  function automatic int digit_width(input int unsigned width);
    return (clog2(width) < 1) ? 1 : clog2(width);
  endfunction

endpackage

// File: rtl/lock_cycle_timer.sv
// Loadable down-counter with a one-cycle expiry indication. Shared by the
// inactivity timeout and the ERROR/lockout hold, which never overlap.
// Loading N makes o_expire assert in the N-th cycle after the load.
module lock_cycle_timer #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  // Reload on request, otherwise count down and stop at zero (never wraps).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expire = (r_count == W'(1));

endmodule

// File: rtl/lock_code_sequencer.sv
// Code-entry controller for the digital lock. Consumes one-cycle keyEdge
// pulses as digits, compares a CODE_LENGTH-digit sequence against the stored
// code and drives locked/unlocked/error status. While unlocked the stored
// code can be reprogrammed from the keypad.
// Optional build macro LOCK_FAIL_LOCKOUT_EN adds a consecutive-failure
// counter that stretches the MAX_FAILS-th ERROR to LOCKOUT_CYCLES with
// lockout asserted.
module lock_code_sequencer
  import lock_pkg::*;
#(
  parameter int          WIDTH          = 4,
  parameter int          CODE_LENGTH    = 4,
  parameter logic [CODE_LENGTH*digit_width(WIDTH)-1:0] RESET_CODE = 8'hE4,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned ERROR_CYCLES   = 25_000_000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [WIDTH-1:0]                 keyEdge,
  input  logic                             lockCmd,
  input  logic                             setCode,
  output logic                             locked,
  output logic                             unlocked,
  output logic                             error,
  output logic                             lockout,
  output logic [clog2(CODE_LENGTH+1)-1:0]  digitCount,
  output logic [2:0]                       state
);

  localparam int DIGIT_W = digit_width(WIDTH);
  localparam int CODE_W  = CODE_LENGTH * DIGIT_W;
  localparam int CNT_W   = clog2(CODE_LENGTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CODE_LENGTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CODE_LENGTH - 1);

  // One timer serves every hold, so it is sized for the longest one.
  localparam int unsigned HOLD_A   = (TIMEOUT_CYCLES > ERROR_CYCLES) ? TIMEOUT_CYCLES : ERROR_CYCLES;
  localparam int unsigned HOLD_MAX = (HOLD_A > LOCKOUT_CYCLES) ? HOLD_A : LOCKOUT_CYCLES;
  localparam int          TIMER_W  = clog2(HOLD_MAX + 1);

  localparam logic [TIMER_W-1:0] T_TIMEOUT = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] T_ERROR   = TIMER_W'(ERROR_CYCLES);

  lock_state_t        r_state;
  lock_state_t        w_state_next;
  logic [CNT_W-1:0]   r_digit_count;
  logic [CNT_W-1:0]   w_count_next;
  logic               r_mismatch;
  logic               w_mismatch_next;
  logic [CODE_W-1:0]  r_code;
  logic [CODE_W-1:0]  r_shadow;
  logic [CODE_W-1:0]  w_shadow_merged;

  logic               w_key_any;
  logic               w_key_multi;
  logic [DIGIT_W-1:0] w_key_terms [WIDTH];
  logic [DIGIT_W-1:0] w_key_digit;
  logic [DIGIT_W-1:0] w_code_digit;
  logic               w_digit_bad;

  logic               w_timer_load;
  logic [TIMER_W-1:0] w_timer_value;
  logic               w_timer_expire;
  logic [TIMER_W-1:0] w_error_value;
  logic               w_lockout_active;
  logic               w_commit;
  logic               w_shadow_write;

  // ---------------------------------------------------------------------
  // Key decode: any bit set is a digit; more than one bit is never valid.
  // ---------------------------------------------------------------------
  assign w_key_any   = |keyEdge;
  assign w_key_multi = |(keyEdge & (keyEdge - WIDTH'(1)));

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_key_term
    assign w_key_terms[gi] = keyEdge[gi] ? DIGIT_W'(gi) : '0;
  end

  // OR of per-key index terms; exact for a one-hot keyEdge.
  always_comb begin
    w_key_digit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_key_digit = w_key_digit | w_key_terms[i];
    end
  end

  // Stored code digit at the current entry position.
  always_comb begin
    w_code_digit = '0;
    for (int i = 0; i < CODE_LENGTH; i++) begin
      if (r_digit_count == CNT_W'(i)) begin
        w_code_digit = r_code[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign w_digit_bad = w_key_multi || (w_key_digit != w_code_digit);

  // Shadow code with the incoming digit dropped into slot digitCount.
  for (genvar gi = 0; gi < CODE_LENGTH; gi++) begin : g_shadow_slot
    assign w_shadow_merged[gi*DIGIT_W +: DIGIT_W] =
      (r_digit_count == CNT_W'(gi)) ? w_key_digit : r_shadow[gi*DIGIT_W +: DIGIT_W];
  end

  // ---------------------------------------------------------------------
  // Consecutive-failure lockout
  // ---------------------------------------------------------------------
`ifdef LOCK_FAIL_LOCKOUT_EN
  localparam int FAIL_W = (clog2(MAX_FAILS + 1) < 2) ? 2 : clog2(MAX_FAILS + 1);
  localparam logic [FAIL_W-1:0]  FAIL_LIMIT = FAIL_W'(MAX_FAILS);
  localparam logic [TIMER_W-1:0] T_LOCKOUT  = TIMER_W'(LOCKOUT_CYCLES);

  logic [FAIL_W-1:0] r_fail_count;
  logic [FAIL_W-1:0] w_fail_inc;
  logic              w_lockout_trip;
  logic              r_lockout_hold;

  assign w_fail_inc     = (r_fail_count == '1) ? r_fail_count : r_fail_count + FAIL_W'(1);
  assign w_lockout_trip = (w_fail_inc >= FAIL_LIMIT);
  assign w_error_value  = w_lockout_trip ? T_LOCKOUT : T_ERROR;

  // Count failed checks; a pass clears, and a completed lockout starts over.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fail_count   <= '0;
      r_lockout_hold <= 1'b0;
    end else if (r_state == ST_CHECK) begin
      if (r_mismatch) begin
        r_fail_count   <= w_fail_inc;
        r_lockout_hold <= w_lockout_trip;
      end else begin
        r_fail_count   <= '0;
      end
    end else if ((r_state == ST_ERROR) && w_timer_expire && r_lockout_hold) begin
      r_fail_count   <= '0;
      r_lockout_hold <= 1'b0;
    end
  end

  assign w_lockout_active = r_lockout_hold;
`else
  assign w_error_value    = T_ERROR;
  assign w_lockout_active = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_LOCKED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus the datapath controls that go with each transition.
  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_digit_count;
    w_mismatch_next = r_mismatch;
    w_timer_load    = 1'b0;
    w_timer_value   = T_TIMEOUT;
    w_commit        = 1'b0;
    w_shadow_write  = 1'b0;
    case (r_state)
      ST_LOCKED: begin
        if (w_key_any) begin
          w_state_next    = ST_ENTRY;
          w_count_next    = CNT_W'(1);
          w_mismatch_next = w_digit_bad;
          w_timer_load    = 1'b1;
        end
      end
      ST_ENTRY: begin
        // A full sequence waits one cycle here before the verdict.
        if (r_digit_count == CNT_FULL) begin
          w_state_next = ST_CHECK;
        end else if (w_key_any) begin
          // A digit beats a simultaneous timeout and restarts the timer.
          w_count_next    = r_digit_count + CNT_W'(1);
          w_mismatch_next = r_mismatch | w_digit_bad;
          w_timer_load    = 1'b1;
        end else if (w_timer_expire) begin
          w_state_next    = ST_LOCKED;
          w_count_next    = '0;
          w_mismatch_next = 1'b0;
        end
      end
      ST_CHECK: begin
        w_count_next    = '0;
        w_mismatch_next = 1'b0;
        if (r_mismatch) begin
          w_state_next  = ST_ERROR;
          w_timer_load  = 1'b1;
          w_timer_value = w_error_value;
        end else begin
          w_state_next  = ST_UNLOCKED;
        end
      end
      ST_UNLOCKED: begin
        w_count_next = '0;
        if (lockCmd) begin
          w_state_next = ST_LOCKED;
        end else if (setCode) begin
          w_state_next = ST_PROGRAM;
          w_timer_load = 1'b1;
        end
      end
      ST_PROGRAM: begin
        if (w_key_any) begin
          if (w_key_multi) begin
            w_state_next = ST_UNLOCKED;
            w_count_next = '0;
          end else if (r_digit_count == CNT_LAST) begin
            w_state_next = ST_UNLOCKED;
            w_count_next = '0;
            w_commit     = 1'b1;
          end else begin
            w_count_next   = r_digit_count + CNT_W'(1);
            w_shadow_write = 1'b1;
            w_timer_load   = 1'b1;
          end
        end else if (w_timer_expire) begin
          w_state_next = ST_UNLOCKED;
          w_count_next = '0;
        end
      end
      ST_ERROR: begin
        w_count_next = '0;
        if (w_timer_expire) begin
          w_state_next = ST_LOCKED;
        end
      end
      default: begin
        w_state_next    = ST_LOCKED;
        w_count_next    = '0;
        w_mismatch_next = 1'b0;
      end
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    locked   = 1'b0;
    unlocked = 1'b0;
    error    = 1'b0;
    lockout  = 1'b0;
    case (r_state)
      ST_LOCKED, ST_ENTRY, ST_CHECK: locked = 1'b1;
      ST_UNLOCKED, ST_PROGRAM:       unlocked = 1'b1;
      ST_ERROR: begin
        locked  = 1'b1;
        error   = 1'b1;
        lockout = w_lockout_active;
      end
      default:                       locked = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------

  // Entry position and sticky mismatch for the sequence in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_digit_count <= '0;
      r_mismatch    <= 1'b0;
    end else begin
      r_digit_count <= w_count_next;
      r_mismatch    <= w_mismatch_next;
    end
  end

  // Stored code and programming shadow; the final digit commits the merge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_code   <= RESET_CODE;
      r_shadow <= '0;
    end else begin
      if (w_shadow_write) begin
        r_shadow <= w_shadow_merged;
      end
      if (w_commit) begin
        r_code <= w_shadow_merged;
      end
    end
  end

  lock_cycle_timer #(
    .W (TIMER_W)
  ) u_timer (
    .i_clk    (clock),
    .i_rst_n  (reset),
    .i_load   (w_timer_load),
    .i_value  (w_timer_value),
    .o_expire (w_timer_expire)
  );

  assign state      = r_state;
  assign digitCount = r_digit_count;

endmodule

// File: tb/tb_lock_code_sequencer.sv
// Scoreboard bench for lock_code_sequencer. Stimulus tasks push the expected
// state transitions (state, digitCount, lockout, cycle of arrival) into a
// queue; a monitor pops one entry per observed state change and compares.
module tb_lock_code_sequencer;

  localparam logic [2:0] S_LOCKED   = 3'd0;
  localparam logic [2:0] S_ENTRY    = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_UNLOCKED = 3'd3;
  localparam logic [2:0] S_PROGRAM  = 3'd4;
  localparam logic [2:0] S_ERROR    = 3'd5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] keyEdge = 4'b0000;
  logic       lockCmd = 1'b0;
  logic       setCode = 1'b0;
  logic       locked, unlocked, error, lockout;
  logic [2:0] digitCount;
  logic [2:0] state;

  lock_code_sequencer #(
    .TIMEOUT_CYCLES (20),
    .ERROR_CYCLES   (5),
    .LOCKOUT_CYCLES (15)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .keyEdge    (keyEdge),
    .lockCmd    (lockCmd),
    .setCode    (setCode),
    .locked     (locked),
    .unlocked   (unlocked),
    .error      (error),
    .lockout    (lockout),
    .digitCount (digitCount),
    .state      (state)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] st;
    logic [2:0] dc;
    logic       lo;
    int         at;   // expected cycle of arrival, -1 = any
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  logic [2:0] prev_state = 3'd0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every state change is one transaction, checked against the queue.
  always @(negedge clock) begin
    if (mon_en && (state !== prev_state)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transition: got state %0d at cycle %0d, expected none", state, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("transition: state=%0d digitCount=%0d locked=%0b unlocked=%0b error=%0b lockout=%0b cycle=%0d",
                 state, digitCount, locked, unlocked, error, lockout, cyc);
        check("state", int'(state), int'(e.st));
        check("digitCount", int'(digitCount), int'(e.dc));
        check("locked", int'(locked), int'(e.st inside {S_LOCKED, S_ENTRY, S_CHECK, S_ERROR}));
        check("unlocked", int'(unlocked), int'(e.st inside {S_UNLOCKED, S_PROGRAM}));
        check("error", int'(error), int'(e.st == S_ERROR));
        check("lockout", int'(lockout), int'(e.lo));
        if (e.at >= 0) check("arrival_cycle", cyc, e.at);
      end
    end
    prev_state = state;
  end

  task automatic push(input logic [2:0] st, input logic [2:0] dc, input logic lo, input int at);
    exp_t e;
    e.st = st;
    e.dc = dc;
    e.lo = lo;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  // One-cycle keyEdge pulse, driven just after a falling edge.
  task automatic key(input logic [3:0] k);
    keyEdge = k;
    @(negedge clock);
    keyEdge = 4'b0000;
  endtask

  // Four-key entry from LOCKED: either unlocks, or errors for 5 (15 in lockout) cycles.
  task automatic code_seq(input logic [3:0] k0, input logic [3:0] k1, input logic [3:0] k2,
                          input logic [3:0] k3, input bit ok, input bit lo);
    int t;
    int hold;
    t    = cyc;
    hold = lo ? 15 : 5;
    push(S_ENTRY, 3'd1, 1'b0, t + 1);
    push(S_CHECK, 3'd4, 1'b0, t + 5);
    if (ok) begin
      push(S_UNLOCKED, 3'd0, 1'b0, t + 6);
    end else begin
      push(S_ERROR, 3'd0, lo, t + 6);
      push(S_LOCKED, 3'd0, 1'b0, t + 6 + hold);
    end
    key(k0);
    key(k1);
    key(k2);
    key(k3);
    wait_until(ok ? t + 6 : t + 6 + hold);
  endtask

  task automatic relock();
    int t;
    t = cyc;
    push(S_LOCKED, 3'd0, 1'b0, t + 1);
    lockCmd = 1'b1;
    @(negedge clock);
    lockCmd = 1'b0;
  endtask

  task automatic program_seq(input logic [3:0] k0, input logic [3:0] k1,
                             input logic [3:0] k2, input logic [3:0] k3);
    int t;
    t = cyc;
    push(S_PROGRAM, 3'd0, 1'b0, t + 1);
    push(S_UNLOCKED, 3'd0, 1'b0, t + 5);
    setCode = 1'b1;
    @(negedge clock);
    setCode = 1'b0;
    key(k0);
    key(k1);
    key(k2);
    key(k3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(negedge clock);
    // Reset state, sampled while reset is held low.
    check("reset_state", int'(state), int'(S_LOCKED));
    check("reset_locked", int'(locked), 1);
    check("reset_unlocked", int'(unlocked), 0);
    check("reset_error", int'(error), 0);
    check("reset_lockout", int'(lockout), 0);
    check("reset_digitCount", int'(digitCount), 0);
    reset      = 1'b1;
    prev_state = state;
    mon_en     = 1'b1;
    @(negedge clock);

    // Correct default code 0,1,2,3 then relock.
    code_seq(4'b0001, 4'b0010, 4'b0100, 4'b1000, 1'b1, 1'b0);
    relock();

    // Wrong code 0,1,3,3, then the right one unlocks.
    code_seq(4'b0001, 4'b0010, 4'b1000, 4'b1000, 1'b0, 1'b0);
    code_seq(4'b0001, 4'b0010, 4'b0100, 4'b1000, 1'b1, 1'b0);
    relock();

    // Multi-key first digit poisons the sequence.
    code_seq(4'b0011, 4'b0010, 4'b0100, 4'b1000, 1'b0, 1'b0);

    // Two digits then silence: timeout back to LOCKED after 20 idle cycles.
    t = cyc;
    push(S_ENTRY, 3'd1, 1'b0, t + 1);
    push(S_LOCKED, 3'd0, 1'b0, t + 22);
    key(4'b0001);
    key(4'b0010);
    wait_until(t + 22);

    // Reprogram to 3,3,2,1; old code then fails, new code unlocks.
    code_seq(4'b0001, 4'b0010, 4'b0100, 4'b1000, 1'b1, 1'b0);
    program_seq(4'b1000, 4'b1000, 4'b0100, 4'b0010);
    relock();
    code_seq(4'b0001, 4'b0010, 4'b0100, 4'b1000, 1'b0, 1'b0);
    code_seq(4'b1000, 4'b1000, 4'b0100, 4'b0010, 1'b1, 1'b0);

    // Reset in the middle of programming restores the default code.
    t = cyc;
    push(S_PROGRAM, 3'd0, 1'b0, t + 1);
    setCode = 1'b1;
    @(negedge clock);
    setCode = 1'b0;
    key(4'b0001);
    key(4'b0001);
    #1;
    reset = 1'b0;
    push(S_LOCKED, 3'd0, 1'b0, -1);
    @(negedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    code_seq(4'b0001, 4'b0010, 4'b0100, 4'b1000, 1'b1, 1'b0);

    // lockCmd and setCode together: relock wins.
    t = cyc;
    push(S_LOCKED, 3'd0, 1'b0, t + 1);
    lockCmd = 1'b1;
    setCode = 1'b1;
    @(negedge clock);
    lockCmd = 1'b0;
    setCode = 1'b0;

`ifdef LOCK_FAIL_LOCKOUT_EN
    // Third consecutive failure holds for the lockout duration.
    code_seq(4'b0001, 4'b0010, 4'b1000, 4'b1000, 1'b0, 1'b0);
    code_seq(4'b0001, 4'b0010, 4'b1000, 4'b1000, 1'b0, 1'b0);
    code_seq(4'b0001, 4'b0010, 4'b1000, 4'b1000, 1'b0, 1'b1);
    // Two failures then a success clears the count.
    code_seq(4'b0001, 4'b0010, 4'b1000, 4'b1000, 1'b0, 1'b0);
    code_seq(4'b0001, 4'b0010, 4'b1000, 4'b1000, 1'b0, 1'b0);
    code_seq(4'b0001, 4'b0010, 4'b0100, 4'b1000, 1'b1, 1'b0);
    relock();
    code_seq(4'b0001, 4'b0010, 4'b1000, 4'b1000, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_transitions: got %0d still outstanding, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lock_code_sequencer.md
Name: lock_code_sequencer

Overview:
- Code-entry controller for the digital lock.
- Sits directly downstream of the n-bit button monitor and consumes its one-cycle keyEdge pulses, each treated as one entered digit.
- Collects CODE_LENGTH digits, compares them against a stored code, and drives lock/unlock/error status.
- While unlocked, allows the stored code to be reprogrammed by keypad.

Parameters:
- WIDTH, 4: number of keys / keyEdge bits. Digit value = key index. DIGIT_W = max(1, clog2(WIDTH)).
- CODE_LENGTH, 4: digits per code.
- RESET_CODE, 8'hE4: code loaded at reset, CODE_LENGTH*DIGIT_W bits. Digit i sits at [i*DIGIT_W +: DIGIT_W]; digit 0 is entered first. The default is the sequence 0,1,2,3.
- TIMEOUT_CYCLES, 50_000_000: inactivity limit during entry or programming.
- ERROR_CYCLES, 25_000_000: duration of the ERROR state.
- MAX_FAILS, 3: consecutive failures before lockout (LOCKOUT_EN only).
- LOCKOUT_CYCLES, 500_000_000: lockout hold duration (LOCKOUT_EN only).

Ports:
- clock, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- keyEdge, input, WIDTH: one-cycle key-press pulses from the button monitor.
- lockCmd, input, 1: relock pulse. Honoured only in UNLOCKED.
- setCode, input, 1: enter-programming pulse. Honoured only in UNLOCKED.
- locked, output, 1: high in LOCKED, ENTRY, CHECK, ERROR.
- unlocked, output, 1: high in UNLOCKED and PROGRAM.
- error, output, 1: high in ERROR.
- lockout, output, 1: high during an extended lockout hold.
- digitCount, output, clog2(CODE_LENGTH+1): digits entered in the current sequence.
- state, output, 3: current state encoding, for display/debug.

Behaviour:
- Reset (reset low), asynchronous:
  - state=LOCKED, locked=1, unlocked=0, error=0, lockout=0, digitCount=0.
  - Code register = RESET_CODE; mismatch flag cleared; fail counter cleared; timers cleared.
  - Reset mid-entry or mid-programming discards all partial digits.
- Digit acceptance:
  - A cycle with exactly one keyEdge bit set yields digit = that index.
  - More than one bit set counts as one digit and forces the mismatch flag (it is never a valid digit).
  - No bits set: no digit.
- LOCKED: on first digit, store/compare it, set digitCount=1, go to ENTRY.
- ENTRY:
  - Each digit is compared against code digit[digitCount]; any mismatch sets the sticky mismatch flag; digitCount increments.
  - When the CODE_LENGTH-th digit is accepted, go to CHECK on the next cycle.
- CHECK (1 cycle):
  - mismatch=0 → UNLOCKED. Otherwise → ERROR.
  - Clears digitCount and the mismatch flag.
  - unlocked rises exactly 2 clocks after the clock edge sampling the final keyEdge.
- UNLOCKED:
  - keyEdge ignored.
  - lockCmd → LOCKED.
  - setCode → PROGRAM.
  - lockCmd and setCode in the same cycle: lockCmd wins.
- PROGRAM:
  - Each accepted digit is written to a shadow register at position digitCount.
  - A multi-bit keyEdge aborts programming: return to UNLOCKED, code unchanged.
  - After CODE_LENGTH digits, the shadow is copied to the code register in one cycle; return to UNLOCKED with digitCount=0.
- ERROR: hold for ERROR_CYCLES (or LOCKOUT_CYCLES when a lockout is active), then LOCKED. keyEdge ignored.
- Inactivity timeout:
  - In ENTRY or PROGRAM, the timer reloads on each accepted digit.
  - Expiry after TIMEOUT_CYCLES without a digit: ENTRY → LOCKED, PROGRAM → UNLOCKED (code unchanged). digitCount is cleared.
- Simultaneous digit and timeout expiry in the same cycle: the digit wins and the timer reloads.
- Counters saturate; they never wrap.

Optional Feature:
- Macro: LOCK_FAIL_LOCKOUT_EN.
- Defined:
  - 2-bit+ fail counter increments on each CHECK→ERROR and clears on CHECK→UNLOCKED.
  - When the counter reaches MAX_FAILS, ERROR holds for LOCKOUT_CYCLES with lockout=1, then the counter clears.
- Undefined: no fail counter; ERROR always lasts ERROR_CYCLES; lockout tied to 0.

Decomposition:
- Shared package lock_pkg holds:
  - state encodings: LOCKED=0, ENTRY=1, CHECK=2, UNLOCKED=3, PROGRAM=4, ERROR=5;
  - a clog2 constant function;
  - DIGIT_W derivation.
- One natural sub-module: lock_cycle_timer, a loadable down-counter with expiry pulse. It is instantiated once and shared by the timeout and ERROR/lockout holds, since they are mutually exclusive by state.

Test Plan:
- Bench parameters for all scenarios: TIMEOUT_CYCLES=20, ERROR_CYCLES=5, LOCKOUT_CYCLES=15.
- Correct code: reset, then keyEdge pulses 0001,0010,0100,1000 (digits 0,1,2,3) → unlocked=1 two cycles after the last pulse; locked=0; digitCount back to 0.
- Wrong code: digits 0,1,3,3 → one CHECK cycle, then error=1 for 5 cycles, then LOCKED. A following 0,1,2,3 unlocks.
- Multi-key and timeout: keyEdge=0011 as digit 0, then 1,2,3 → ERROR. Separately, digits 0,1 then 20 idle cycles → LOCKED, digitCount=0, no error.
- Reprogram: unlock; setCode pulse; digits 3,3,2,1 → UNLOCKED. lockCmd → LOCKED. Digits 0,1,2,3 → ERROR; digits 3,3,2,1 → UNLOCKED.
- Reset mid-operation: assert reset low during PROGRAM after 2 digits → immediate LOCKED with code back to 0,1,2,3. Also assert lockCmd and setCode in the same cycle in UNLOCKED → LOCKED.
- With LOCK_FAIL_LOCKOUT_EN: three wrong codes → third ERROR holds 15 cycles with lockout=1. Two wrong codes then a correct one → counter cleared; the next wrong code gives a 5-cycle ERROR.
